tmds_pll_supervisor: RTL and testbench

Single-clock supervisor for the TMDS output PLL (serial and pixel clock generator).
- Drives the PLL reset and debounces/synchronises the PLL locked flag.
- Retries PLL reset on lock timeout, up to a limit, and latches a fault when the budget is spent.
- Releases per-domain resets in a staggered sequence, for NUM_DOMAINS consumers (serializer, pixel pipe, ...).
- Runs from the free-running reference clock, so it operates while the PLL is unlocked.

---
 rtl/tmds_pll_pkg.sv | 25 ++
 rtl/tmds_pll_supervisor_if.sv | 30 +++
 rtl/pll_lock_sync.sv | 21 ++
 rtl/tmds_pll_supervisor.sv | 146 ++++++++++++++
 tb/tb_tmds_pll_supervisor.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/tmds_pll_pkg.sv
// tmds_pll_pkg: shared state encoding and width helpers for the TMDS PLL supervisor
package tmds_pll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESET,
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN,
        FAULT
    } state_t;

    localparam int LOSS_W = 16;

    // Bits needed to hold the values 0..n-1 (at least one bit)
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tmds_pll_supervisor_if.sv
// tmds_pll_supervisor_if: control, PLL and per-domain reset signals of the supervisor
interface tmds_pll_supervisor_if
    import tmds_pll_pkg::*;
#(
    parameter int NUM_DOMAINS = 2,
    parameter int MAX_RETRIES = 3
);
    localparam int RC_W = cw(MAX_RETRIES + 1);

    logic                   enable;
    logic                   clear_fault;
    logic                   pll_locked;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst;
    logic                   ready;
    logic                   fault;
    logic [RC_W-1:0]        retry_count;
    logic [LOSS_W-1:0]      lock_loss_count;

    modport master (
        output enable, clear_fault, pll_locked,
        input  pll_rst, domain_rst, ready, fault, retry_count, lock_loss_count
    );

    modport slave (
        input  enable, clear_fault, pll_locked,
        output pll_rst, domain_rst, ready, fault, retry_count, lock_loss_count
    );

endinterface

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchroniser bringing the PLL lock flag into the refclk domain
module pll_lock_sync (
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Shift the asynchronous flag through two flops to settle metastability
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tmds_pll_supervisor.sv
// tmds_pll_supervisor: PLL reset/retry sequencing, lock qualification and staggered domain reset release
module tmds_pll_supervisor
    import tmds_pll_pkg::*;
#(
    parameter int NUM_DOMAINS         = 2,
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int RELEASE_STAGGER     = 8
) (
    input logic                 refclk,
    input logic                 rst,
    tmds_pll_supervisor_if.slave bus
);
    localparam int RC_W     = cw(MAX_RETRIES + 1);
    localparam int REL_LAST = RELEASE_STAGGER * (NUM_DOMAINS - 1);
    localparam int CW       = cw(maxi(maxi(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES), REL_LAST + 1));
    localparam int SW       = cw(LOCK_STABLE_CYCLES + 1);

    state_t                 st, st_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [SW-1:0]          stab, stab_n;
    logic [RC_W-1:0]        rc, rc_n;
    logic [LOSS_W-1:0]      loss_cnt, loss_n;
    logic                   lock_s, lost;
    logic                   pll_rst_q, pll_rst_n;
    logic [NUM_DOMAINS-1:0] dom_q, dom_n;
    logic                   ready_q, ready_n;
    logic                   fault_q, fault_n;

    pll_lock_sync u_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (bus.pll_locked),
        .q      (lock_s)
    );

    assign bus.pll_rst         = pll_rst_q;
    assign bus.domain_rst      = dom_q;
    assign bus.ready           = ready_q;
    assign bus.fault           = fault_q;
    assign bus.retry_count     = rc;
    assign bus.lock_loss_count = loss_cnt;

    // Next state, counter updates, and outputs decoded from the next state
    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        stab_n = stab;
        rc_n   = rc;
        loss_n = loss_cnt;
        lost   = 1'b0;
        if (!bus.enable) begin
            st_n  = IDLE;
            cnt_n = '0;
            rc_n  = '0;
        end else begin
            case (st)
                IDLE: begin
                    st_n  = PRESET;
                    cnt_n = '0;
                end
                PRESET: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(RESET_PULSE_CYCLES - 1)) begin
                        st_n   = WAIT_LOCK;
                        cnt_n  = '0;
                        stab_n = '0;
                    end
                end
                WAIT_LOCK, STABILIZE: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        cnt_n  = '0;
                        stab_n = '0;
                        st_n   = (rc == RC_W'(MAX_RETRIES)) ? FAULT : PRESET;
                        rc_n   = (rc == RC_W'(MAX_RETRIES)) ? rc : rc + 1'b1;
                    end else if (!lock_s) begin
                        st_n   = WAIT_LOCK;
                        stab_n = '0;
                    end else begin
                        stab_n = stab + 1'b1;
                        st_n   = STABILIZE;
                        if (32'(stab_n) >= LOCK_STABLE_CYCLES) begin
                            st_n  = (REL_LAST == 0) ? RUN : RELEASE;
                            cnt_n = '0;
                        end
                    end
                end
                RELEASE: begin
                    cnt_n = cnt + 1'b1;
                    lost  = !lock_s;
                    if (32'(cnt_n) == REL_LAST) st_n = RUN;
                end
                RUN: lost = !lock_s;
                FAULT: begin
                    if (bus.clear_fault) begin
                        st_n = IDLE;
                        rc_n = '0;
                    end
                end
                default: st_n = IDLE;
            endcase
            if (lost) begin
                st_n   = PRESET;
                cnt_n  = '0;
                stab_n = '0;
                rc_n   = '0;
                loss_n = (&loss_cnt) ? loss_cnt : loss_cnt + 1'b1;
            end
            if (st_n == RUN) rc_n = '0;
        end
        pll_rst_n = !(st_n inside {WAIT_LOCK, STABILIZE, RELEASE, RUN});
        ready_n   = (st_n == RUN);
        fault_n   = (st_n == FAULT);
        for (int i = 0; i < NUM_DOMAINS; i++)
            dom_n[i] = (st_n == RELEASE) ? (32'(cnt_n) < RELEASE_STAGGER * i) : (st_n != RUN);
    end

    // State, counters and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            stab      <= '0;
            rc        <= '0;
            loss_cnt  <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            stab      <= stab_n;
            rc        <= rc_n;
            loss_cnt  <= loss_n;
            pll_rst_q <= pll_rst_n;
            dom_q     <= dom_n;
            ready_q   <= ready_n;
            fault_q   <= fault_n;
        end
    end

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// tb_tmds_pll_supervisor: vector-table and directed-sequence bench for the PLL supervisor
module tb_tmds_pll_supervisor;

    typedef struct {
        int          n;
        logic        en;
        logic        cf;
        logic        lk;
        logic        pr;
        logic [1:0]  dr;
        logic        rdy;
        logic        flt;
        logic [1:0]  rc;
        logic [15:0] loss;
    } vec_t;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   ncmp   = 0;
    int   nerr   = 0;
    vec_t tv[$];

    tmds_pll_supervisor_if #(.NUM_DOMAINS(2), .MAX_RETRIES(2)) bus ();

    tmds_pll_supervisor #(
        .NUM_DOMAINS         (2),
        .RESET_PULSE_CYCLES  (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .RELEASE_STAGGER     (3)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int n, input logic en, input logic cf, input logic lk, input logic pr,
                       input logic [1:0] dr, input logic rdy, input logic flt, input logic [1:0] rc,
                       input logic [15:0] loss);
        tv.push_back('{n, en, cf, lk, pr, dr, rdy, flt, rc, loss});
    endtask

    task automatic chk_all(input string nm, input logic pr, input logic [1:0] dr, input logic rdy,
                           input logic flt, input logic [1:0] rc, input logic [15:0] loss);
        chk({nm, ".pll_rst"}, 32'(bus.pll_rst), 32'(pr));
        chk({nm, ".domain_rst"}, 32'(bus.domain_rst), 32'(dr));
        chk({nm, ".ready"}, 32'(bus.ready), 32'(rdy));
        chk({nm, ".fault"}, 32'(bus.fault), 32'(flt));
        chk({nm, ".retry_count"}, 32'(bus.retry_count), 32'(rc));
        chk({nm, ".lock_loss_count"}, 32'(bus.lock_loss_count), 32'(loss));
    endtask

    task automatic wait_ready(input int max, input string nm);
        int k = 0;
        while (!bus.ready && k < max) begin
            @(negedge refclk);
            k++;
        end
        chk(nm, 32'(bus.ready), 32'd1);
    endtask

    task automatic lock_glitch();
        bus.pll_locked = 1'b0;
        @(negedge refclk);
        bus.pll_locked = 1'b1;
        repeat (2) @(negedge refclk);
    endtask

    initial begin
        // clean bring-up
        add(1, 1, 0, 0, 1, 2'b11, 0, 0, 0, 0);
        add(3, 1, 0, 0, 1, 2'b11, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
        add(9, 1, 0, 1, 0, 2'b11, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 2'b10, 0, 0, 0, 0);
        add(2, 1, 0, 1, 0, 2'b10, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 2'b00, 1, 0, 0, 0);
        // disable, then glitchy lock during stabilisation
        add(1, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0);
        add(5, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
        add(5, 1, 0, 1, 0, 2'b11, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0);
        add(4, 1, 0, 1, 0, 2'b11, 0, 0, 0, 0);
        add(5, 1, 0, 1, 0, 2'b11, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 2'b10, 0, 0, 0, 0);
        add(3, 1, 0, 1, 0, 2'b00, 1, 0, 0, 0);
        // lock loss in RUN and re-release
        add(1, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        add(2, 1, 0, 1, 1, 2'b11, 0, 0, 0, 1);
        add(4, 1, 0, 1, 0, 2'b11, 0, 0, 0, 1);
        add(7, 1, 0, 1, 0, 2'b11, 0, 0, 0, 1);
        add(1, 1, 0, 1, 0, 2'b10, 0, 0, 0, 1);
        add(3, 1, 0, 1, 0, 2'b00, 1, 0, 0, 1);
        // never locks: three attempts, fault, clear
        add(1, 0, 0, 0, 1, 2'b11, 0, 0, 0, 1);
        add(5, 1, 0, 0, 0, 2'b11, 0, 0, 0, 1);
        add(31, 1, 0, 0, 0, 2'b11, 0, 0, 0, 1);
        add(1, 1, 0, 0, 1, 2'b11, 0, 0, 1, 1);
        add(4, 1, 0, 0, 0, 2'b11, 0, 0, 1, 1);
        add(31, 1, 0, 0, 0, 2'b11, 0, 0, 1, 1);
        add(1, 1, 0, 0, 1, 2'b11, 0, 0, 2, 1);
        add(4, 1, 0, 0, 0, 2'b11, 0, 0, 2, 1);
        add(31, 1, 0, 0, 0, 2'b11, 0, 0, 2, 1);
        add(1, 1, 0, 0, 1, 2'b11, 0, 1, 2, 1);
        add(5, 1, 0, 0, 1, 2'b11, 0, 1, 2, 1);
        add(1, 1, 1, 0, 1, 2'b11, 0, 0, 0, 1);
        add(5, 1, 0, 0, 0, 2'b11, 0, 0, 0, 1);
        // enable dropped mid-release
        add(9, 1, 0, 1, 0, 2'b11, 0, 0, 0, 1);
        add(1, 1, 0, 1, 0, 2'b10, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 2'b11, 0, 0, 0, 1);

        bus.enable      = 1'b0;
        bus.clear_fault = 1'b0;
        bus.pll_locked  = 1'b0;
        repeat (2) @(negedge refclk);
        chk_all("reset", 1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 16'h0);
        rst = 1'b0;

        foreach (tv[i]) begin
            bus.enable      = tv[i].en;
            bus.clear_fault = tv[i].cf;
            bus.pll_locked  = tv[i].lk;
            repeat (tv[i].n) @(negedge refclk);
            chk_all($sformatf("v%0d", i), tv[i].pr, tv[i].dr, tv[i].rdy, tv[i].flt, tv[i].rc, tv[i].loss);
        end

        // lock-loss counter saturation
        bus.enable     = 1'b1;
        bus.pll_locked = 1'b1;
        wait_ready(60, "sat_bringup");
        force dut.loss_cnt = 16'hfffe;
        @(negedge refclk);
        release dut.loss_cnt;
        lock_glitch();
        chk("sat_inc.ready", 32'(bus.ready), 32'd0);
        chk("sat_inc.domain_rst", 32'(bus.domain_rst), 32'h3);
        chk("sat_inc.loss", 32'(bus.lock_loss_count), 32'hffff);
        wait_ready(40, "sat_relock");
        lock_glitch();
        chk("sat_hold.loss", 32'(bus.lock_loss_count), 32'hffff);
        wait_ready(40, "sat_relock2");

        // asynchronous reset while running
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
